// File: rtl/key_press_scheduler.sv
// Note sequencer: buffers requested frequencies, looks each one up in an external key map and
// fires a single solenoid for a fixed press time followed by a release hold-off.
module key_press_scheduler #(
   parameter int unsigned PRESS_CYCLES   = 5000000,
   parameter int unsigned HOLDOFF_CYCLES = 2000000,
   parameter int unsigned FIFO_DEPTH     = 4
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic [12:0] note_freq_in,
   input  logic        note_valid_in,
   output logic        note_ready_out,
   output logic [12:0] map_freq_out,
   input  logic [4:0]  map_key_in,
   output logic [23:0] solenoid_out,
   output logic        busy_out,
   output logic [7:0]  drop_count_out
);

   localparam int unsigned AddrW     = $clog2(FIFO_DEPTH);
   localparam int unsigned MaxCycles = (PRESS_CYCLES > HOLDOFF_CYCLES) ? PRESS_CYCLES
                                                                       : HOLDOFF_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);
   localparam logic [CntW-1:0] PressLoad   = CntW'(PRESS_CYCLES - 1);
   localparam logic [CntW-1:0] HoldoffLoad = CntW'(HOLDOFF_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StLookup, StCheck, StPress, StHoldoff} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [4:0]        key_q, key_d;
   logic [12:0]       map_freq_q, map_freq_d;
   logic [23:0]       sol_q, sol_d;
   logic [7:0]        drop_q, drop_d;

   logic [12:0]       fifo_mem [FIFO_DEPTH];
   logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [AddrW:0]    count_q;
   logic              full, empty, push, pop;
   logic [4:0]        key_idx;

   assign full           = (count_q == (AddrW + 1)'(FIFO_DEPTH));
   assign empty          = (count_q == '0);
   // Held low while in reset so no transfer can be claimed before the FIFO is live.
   assign note_ready_out = rst_n_in && !full;
   assign push           = note_valid_in && note_ready_out;

   assign key_idx = (key_q[4] ? 5'd12 : 5'd0) + {1'b0, key_q[3:0]};

   always_ff @(posedge clk_in) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= note_freq_in;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (AddrW + 1)'(1);
            2'b01:   count_q <= count_q - (AddrW + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      key_d      = key_q;
      map_freq_d = map_freq_q;
      sol_d      = sol_q;
      drop_d     = drop_q;
      pop        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!empty) begin
               pop        = 1'b1;
               map_freq_d = fifo_mem[rd_ptr_q];
               state_d    = StLookup;
            end
         end
         StLookup: begin
            key_d   = map_key_in;
            state_d = StCheck;
         end
         StCheck: begin
            if (key_q[3:0] > 4'd11 || map_freq_q == '0) begin
               if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
               state_d = StIdle;
            end else begin
               cnt_d   = PressLoad;
               sol_d   = 24'(1) << key_idx;
               state_d = StPress;
            end
         end
         StPress: begin
            if (cnt_q == '0) begin
               sol_d   = '0;
               cnt_d   = HoldoffLoad;
               state_d = StHoldoff;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StHoldoff: begin
            if (cnt_q == '0) state_d = StIdle;
            else             cnt_d   = cnt_q - CntW'(1);
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         key_q      <= '0;
         map_freq_q <= '0;
         sol_q      <= '0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         key_q      <= key_d;
         map_freq_q <= map_freq_d;
         sol_q      <= sol_d;
         drop_q     <= drop_d;
      end
   end

   assign map_freq_out   = map_freq_q;
   assign solenoid_out   = sol_q;
   assign drop_count_out = drop_q;
   assign busy_out       = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_key_press_scheduler.sv
// Bench for key_press_scheduler: small stub key map, scoreboard of expected solenoid indices,
// vector table plus hand-timed sequences.
module tb_key_press_scheduler;

   localparam int unsigned Press   = 8;
   localparam int unsigned Holdoff = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [12:0] note_freq = '0;
   logic        note_valid = 1'b0;
   logic        note_ready;
   logic [12:0] map_freq;
   logic [4:0]  map_key;
   logic [23:0] solenoid;
   logic        busy;
   logic [7:0]  drop_count;

   int n_cmp = 0;
   int n_bad = 0;
   int sb[$];
   int exp_drop = 0;

   key_press_scheduler #(
      .PRESS_CYCLES  (Press),
      .HOLDOFF_CYCLES(Holdoff),
      .FIFO_DEPTH    (4)
   ) dut (
      .clk_in        (clk),
      .rst_n_in      (rst_n),
      .note_freq_in  (note_freq),
      .note_valid_in (note_valid),
      .note_ready_out(note_ready),
      .map_freq_out  (map_freq),
      .map_key_in    (map_key),
      .solenoid_out  (solenoid),
      .busy_out      (busy),
      .drop_count_out(drop_count)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] key_map(input logic [12:0] f);
      case (f)
         13'd0:   return 5'b00000;
         13'd131: return 5'b00000;
         13'd146: return 5'b00010;
         13'd261: return 5'b10000;
         13'd330: return 5'b10100;
         13'd392: return 5'b10111;
         13'd440: return 5'b11001;
         13'd494: return 5'b11011;
         13'd880: return 5'b01001;
         13'd500: return 5'b01100;
         13'd600: return 5'b11101;
         default: return 5'b11111;
      endcase
   endfunction

   assign map_key = key_map(map_freq);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Pulse monitor: each press must match the scoreboard head and last exactly Press cycles.
   bit          in_pulse = 1'b0;
   int          plen = 0;
   logic [23:0] cur_sol = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         in_pulse = 1'b0;
         plen     = 0;
      end else if (solenoid != '0) begin
         if (!in_pulse) begin
            in_pulse = 1'b1;
            plen     = 1;
            cur_sol  = solenoid;
            if (sb.size() == 0) begin
               check("sb_unexpected_press", solenoid, 0);
            end else begin
               int idx;
               idx = sb.pop_front();
               check("sb_press_key", solenoid, 24'(1) << idx);
            end
         end else begin
            plen++;
            if (solenoid != cur_sol) check("pulse_stable", solenoid, cur_sol);
         end
      end else if (in_pulse) begin
         in_pulse = 1'b0;
         check("pulse_len", plen, Press);
      end
   end

   task automatic send(input logic [12:0] f, input int idx, input bit ok, input bit keep);
      int g = 0;
      @(negedge clk);
      note_freq  = f;
      note_valid = 1'b1;
      while (!note_ready && g < 500) begin
         @(negedge clk);
         g++;
      end
      if (g >= 500) check("send_ready_timeout", note_ready, 1);
      @(posedge clk);
      if (ok) sb.push_back(idx);
      else if (exp_drop < 255) exp_drop++;
      #1;
      if (!keep) note_valid = 1'b0;
   endtask

   task automatic wait_idle(input int bound);
      int g = 0;
      @(negedge clk);
      while (busy && g < bound) begin
         @(negedge clk);
         g++;
      end
      check("wait_idle", busy, 0);
   endtask

   task automatic wait_press();
      int g = 0;
      while (solenoid == '0 && g < 200) begin
         @(negedge clk);
         g++;
      end
      check("wait_press", (solenoid != '0), 1);
   endtask

   typedef struct {
      logic [12:0] freq;
      int          idx;
      bit          ok;
   } vec_t;

   vec_t vecs[8];
   logic [12:0] burst[6];
   int burst_idx[6];

   initial begin
      int h, z;
      vecs[0] = '{440,  21, 1'b1};
      vecs[1] = '{261,  12, 1'b1};
      vecs[2] = '{494,  23, 1'b1};
      vecs[3] = '{131,   0, 1'b1};
      vecs[4] = '{1000,  0, 1'b0};
      vecs[5] = '{0,     0, 1'b0};
      vecs[6] = '{500,   0, 1'b0};
      vecs[7] = '{600,   0, 1'b0};
      burst = '{131, 146, 261, 330, 392, 494};
      burst_idx = '{0, 2, 12, 16, 19, 23};

      // Reset values
      #3;
      check("rst_ready", note_ready, 0);
      check("rst_sol", solenoid, 0);
      check("rst_map", map_freq, 0);
      check("rst_drop", drop_count, 0);
      check("rst_busy", busy, 0);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      #1 check("post_rst_ready", note_ready, 1);

      // 1: single note, cycle-exact timing relative to the accepting edge E0
      send(440, 21, 1'b1, 1'b0);
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 1) check("t1_map_freq", map_freq, 440);
         check($sformatf("t1_sol_E%0d", k), solenoid,
               (k >= 3 && k <= 10) ? (24'(1) << 21) : 24'(0));
         if (k == 14) check("t1_busy_E14", busy, 1);
         if (k == 15) check("t1_busy_E15", busy, 0);
      end

      // 2: back-to-back notes; off time = hold-off plus pop/lookup/check of the next note
      send(146, 2, 1'b1, 1'b0);
      send(261, 12, 1'b1, 1'b0);
      wait_press();
      check("t2_first", solenoid, 24'(1) << 2);
      h = 0;
      while (solenoid != '0 && h < 100) begin
         h++;
         @(negedge clk);
      end
      check("t2_high", h, Press);
      z = 0;
      while (solenoid == '0 && z < 100) begin
         z++;
         @(negedge clk);
      end
      check("t2_gap", z, Holdoff + 3);
      check("t2_second", solenoid, 24'(1) << 12);
      wait_idle(200);

      // 3: invalid key code drops the note and returns to idle three edges after the pop
      send(1000, 0, 1'b0, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 2) check("t3_busy_E2", busy, 1);
         if (k == 3) check("t3_busy_E3", busy, 0);
      end
      check("t3_drop", drop_count, exp_drop);
      check("t3_sol", solenoid, 0);

      // Vector table
      for (int i = 0; i < 8; i++) begin
         send(vecs[i].freq, vecs[i].idx, vecs[i].ok, 1'b0);
         wait_idle(200);
         check($sformatf("vec%0d_drop", i), drop_count, exp_drop);
         check($sformatf("vec%0d_sb", i), sb.size(), 0);
      end

      // 4: stream six notes with valid held high while a note plays
      send(440, 21, 1'b1, 1'b0);
      wait_press();
      for (int i = 0; i < 4; i++) send(burst[i], burst_idx[i], 1'b1, 1'b1);
      @(negedge clk);
      check("t4_full_ready", note_ready, 0);
      check("t4_full_busy", busy, 1);
      send(burst[4], burst_idx[4], 1'b1, 1'b1);
      send(burst[5], burst_idx[5], 1'b1, 1'b0);
      wait_idle(1000);
      check("t4_sb", sb.size(), 0);

      // 5: asynchronous reset during a press discards the queued note
      send(880, 9, 1'b1, 1'b0);
      send(440, 21, 1'b1, 1'b0);
      wait_press();
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t5_sol_async", solenoid, 0);
      check("t5_map", map_freq, 0);
      check("t5_drop", drop_count, 0);
      check("t5_ready_in_rst", note_ready, 0);
      sb.delete();
      exp_drop = 0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      #1;
      check("t5_ready", note_ready, 1);
      check("t5_busy", busy, 0);
      check("t5_drop_after", drop_count, 0);
      repeat (30) @(negedge clk);
      check("t5_no_resume", solenoid, 0);

      // 6: drop counter saturation
      for (int i = 0; i < 10; i++) send(1000, 0, 1'b0, 1'b1);
      note_valid = 1'b0;
      wait_idle(200);
      check("t6_drop10", drop_count, exp_drop);
      for (int i = 0; i < 250; i++) send(1000, 0, 1'b0, 1'b1);
      note_valid = 1'b0;
      wait_idle(2000);
      check("t6_drop_sat", drop_count, 255);
      send(600, 0, 1'b0, 1'b0);
      wait_idle(200);
      check("t6_drop_hold", drop_count, 255);
      check("t6_model", drop_count, exp_drop);

      check("sb_empty_end", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
